// File: rtl/logic_gate_pkg.sv
// Shared op encodings and the bitwise evaluation function for logic_gate_pipe.
// Operands are zero-extended to GATE_MAX_W; callers truncate the result to their width.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam int unsigned GATE_MAX_W = 64;

    function automatic logic [GATE_MAX_W-1:0] gate_eval(
        input logic [GATE_MAX_W-1:0] a,
        input logic [GATE_MAX_W-1:0] b,
        input logic [2:0]            op
    );
        logic [GATE_MAX_W-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_NOT:  r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_fifo2.sv
// Two-entry valid/ready result buffer; in_ready_o depends only on state and reset,
// so there is no combinational path from out_ready_i to in_ready_o.
module gate_fifo2 #(
    parameter int unsigned DW    = 6,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);
    import logic_gate_pkg::*;

    if (DEPTH != 2) begin : g_bad_depth
        $error("gate_fifo2: DEPTH must be 2");
    end

    logic [DW-1:0] mem_q [2];
    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          push, pop;

    assign in_ready_o  = (count_q != 2'd2) & ~rst;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// W-bit selectable bitwise gate with a 2-entry registered valid/ready result buffer.
// Optional sticky OR-accumulator of popped results: define LOGIC_GATE_PIPE_STICKY_EN.
module logic_gate_pipe #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         y_any,
    output logic         y_all
`ifdef LOGIC_GATE_PIPE_STICKY_EN
   ,input  logic         sticky_clr,
    output logic [W-1:0] sticky
`endif
);
    import logic_gate_pkg::*;

    if (W < 1 || W > GATE_MAX_W) begin : g_bad_width
        $error("logic_gate_pipe: W out of range");
    end

    logic [W-1:0] res;
    logic [W+1:0] head;

    assign res = W'(gate_eval(GATE_MAX_W'(a), GATE_MAX_W'(b), op));

    gate_fifo2 #(
        .DW    (W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   ({res, |res, &res}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (head)
    );

    assign y     = head[W+1:2];
    assign y_any = head[1];
    assign y_all = head[0];

`ifdef LOGIC_GATE_PIPE_STICKY_EN
    logic [W-1:0] sticky_q, sticky_d;

    // Clear has priority over accumulating a same-cycle pop.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr)                  sticky_d = '0;
        else if (out_valid && out_ready) sticky_d = sticky_q | y;
    end

    always_ff @(posedge clk) begin
        if (rst) sticky_q <= '0;
        else     sticky_q <= sticky_d;
    end

    assign sticky = sticky_q;
`endif

endmodule
